// File: rtl/dimming_mode_mux_if.sv
// dimming_mode_mux_if: command, sample and result signals of the backlight mode mux.
// Latency: n/a (wiring only). Backpressure: cmd_ready gates commands; samples are never stalled.
// Ports: master = stimulus side (drives cmd/sample inputs), slave = mux side.
// With FRAME_MAX_EN defined, frame_max / frame_max_valid are added to the bundle.
interface dimming_mode_mux_if #(
  parameter int DW     = 8,
  parameter int CH     = 3,
  parameter int VCNT_W = 6
);
  localparam int PW = CH * DW;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_code;
  logic [PW-1:0]     para_list;
  logic              cmd_err;
  logic              frame_start;
  logic [DW-1:0]     white_mean;
  logic [VCNT_W-1:0] white_v_cnt;
  logic              white_valid;
  logic [PW-1:0]     color_mean;
  logic [VCNT_W-1:0] color_v_cnt;
  logic              color_valid;
  logic [PW-1:0]     out_mean;
  logic              out_valid;
  logic [VCNT_W-1:0] out_v_cnt;
  logic [7:0]        active_mode;
`ifdef FRAME_MAX_EN
  logic [PW-1:0]     frame_max;
  logic              frame_max_valid;
`endif

  modport master (
    output cmd_valid, cmd_code, para_list, frame_start,
           white_mean, white_v_cnt, white_valid,
           color_mean, color_v_cnt, color_valid,
    input
`ifdef FRAME_MAX_EN
           frame_max, frame_max_valid,
`endif
           cmd_ready, cmd_err, out_mean, out_valid, out_v_cnt, active_mode
  );

  modport slave (
    input  cmd_valid, cmd_code, para_list, frame_start,
           white_mean, white_v_cnt, white_valid,
           color_mean, color_v_cnt, color_valid,
    output
`ifdef FRAME_MAX_EN
           frame_max, frame_max_valid,
`endif
           cmd_ready, cmd_err, out_mean, out_valid, out_v_cnt, active_mode
  );
endinterface

// File: rtl/dimming_mode_mux.sv
// dimming_mode_mux: applies a frame-aligned dimming mode to grey/colour block means.
// Latency: 2 cycles sample-in to out_valid, 1 sample/cycle. Backpressure: cmd_ready=0 while a
// command waits for frame_start (extra commands dropped); the sample path has no backpressure.
// Ports: clk, rst (async active-high), bus (dimming_mode_mux_if.slave: cmd, samples, result).
// Optional macro FRAME_MAX_EN adds a per-frame, per-channel maximum of out_mean.
module dimming_mode_mux #(
  parameter int DW     = 8,
  parameter int CH     = 3,
  parameter int VCNT_W = 6,
  parameter int PW     = CH * DW
) (
  input  logic             clk,
  input  logic             rst,
  dimming_mode_mux_if.slave bus
);

  localparam logic [7:0] MODE_A0 = 8'hA0;

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  // ---------------- command FSM ----------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_cmd_ready;
  logic          w_shadow_load;
  logic          w_apply;
  logic          w_err_set;
  logic          w_known;
  logic [7:0]    r_shadow_mode;
  logic [PW-1:0] r_shadow_para;
  logic [7:0]    r_active_mode;
  logic [PW-1:0] r_active_para;
  logic          r_cmd_err;

  // Known codes are A0..A3: top six bits fixed, low two bits select the operation.
  assign w_known = (bus.cmd_code[7:2] == 6'b1010_00);

  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_ready   = 1'b0;
    w_shadow_load = 1'b0;
    w_apply       = 1'b0;
    w_err_set     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmd_ready = 1'b1;
        // frame_start here has nothing to apply; a new command waits for the next one.
        if (bus.cmd_valid) begin
          if (w_known) begin
            w_shadow_load = 1'b1;
            w_state_nxt   = ST_PEND;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_PEND: begin
        if (bus.frame_start) begin
          w_apply     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_shadow_mode <= MODE_A0;
      r_shadow_para <= '0;
      r_active_mode <= MODE_A0;
      r_active_para <= '0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd_err <= w_err_set;
      if (w_shadow_load) begin
        r_shadow_mode <= bus.cmd_code;
        r_shadow_para <= bus.para_list;
      end
      if (w_apply) begin
        r_active_mode <= r_shadow_mode;
        r_active_para <= r_shadow_para;
      end
    end
  end

  // ---------------- stage 1: input select + mode snapshot ----------------
  // r_active_mode is the pre-edge value, so a sample coincident with the applying
  // frame_start is tagged with the old mode.
  logic              w_use_white;
  logic              w_sel_valid;
  logic              r_s1_valid;
  logic [PW-1:0]     r_s1_mean;
  logic [VCNT_W-1:0] r_s1_v_cnt;
  logic [1:0]        r_s1_op;
  logic [PW-1:0]     r_s1_para;

  assign w_use_white = (r_active_mode[1] == 1'b0);  // A0, A1
  assign w_sel_valid = w_use_white ? bus.white_valid : bus.color_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mean  <= '0;
      r_s1_v_cnt <= '0;
      r_s1_op    <= 2'd0;
      r_s1_para  <= '0;
    end else begin
      r_s1_valid <= w_sel_valid;
      if (w_sel_valid) begin
        r_s1_mean  <= w_use_white ? PW'(bus.white_mean) : bus.color_mean;
        r_s1_v_cnt <= w_use_white ? bus.white_v_cnt : bus.color_v_cnt;
        r_s1_op    <= r_active_mode[1:0];
        r_s1_para  <= r_active_para;
      end
    end
  end

  // ---------------- stage 2: per-channel arithmetic ----------------
  // op 0 (A0): white - para[B], op 1 (A1): white*para_c, op 2 (A2): color_c*para_c,
  // op 3 (A3): color_c - para_c. Subtractions clamp at 0; products keep the high DW bits.
  logic [CH-1:0][DW-1:0] w_res;

  always_comb begin
    logic [DW-1:0]   v_src;
    logic [DW-1:0]   v_par;
    logic [2*DW-1:0] v_prod;
    w_res  = '0;
    v_src  = '0;
    v_par  = '0;
    v_prod = '0;
    for (int c = 0; c < CH; c++) begin
      v_src  = (r_s1_op[1] == 1'b0) ? r_s1_mean[DW-1:0] : r_s1_mean[c*DW +: DW];
      v_par  = (r_s1_op == 2'd0)    ? r_s1_para[DW-1:0] : r_s1_para[c*DW +: DW];
      v_prod = (2*DW)'(v_src) * (2*DW)'(v_par);
      if (r_s1_op[0] ^ r_s1_op[1]) begin
        w_res[c] = v_prod[2*DW-1:DW];
      end else begin
        w_res[c] = (v_src > v_par) ? (v_src - v_par) : '0;
      end
    end
  end

  logic              r_out_valid;
  logic [PW-1:0]     r_out_mean;
  logic [VCNT_W-1:0] r_out_v_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_mean  <= '0;
      r_out_v_cnt <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_mean  <= w_res;
        r_out_v_cnt <= r_s1_v_cnt;
      end
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.cmd_err     = r_cmd_err;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_mean    = r_out_mean;
  assign bus.out_v_cnt   = r_out_v_cnt;
  assign bus.active_mode = r_active_mode;

`ifdef FRAME_MAX_EN
  // ---------------- per-frame running maximum ----------------
  // w_run_upd folds in the sample visible this cycle, so an out_valid coincident with
  // frame_start is counted in the frame that is ending.
  logic [CH-1:0][DW-1:0] r_run_max;
  logic [CH-1:0][DW-1:0] w_run_upd;
  logic [PW-1:0]         r_frame_max;
  logic                  r_frame_max_valid;

  always_comb begin
    w_run_upd = r_run_max;
    if (r_out_valid) begin
      for (int c = 0; c < CH; c++) begin
        if (r_out_mean[c*DW +: DW] > r_run_max[c]) begin
          w_run_upd[c] = r_out_mean[c*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_max         <= '0;
      r_frame_max       <= '0;
      r_frame_max_valid <= 1'b0;
    end else if (bus.frame_start) begin
      r_frame_max       <= w_run_upd;
      r_frame_max_valid <= 1'b1;
      r_run_max         <= '0;
    end else begin
      r_frame_max_valid <= 1'b0;
      r_run_max         <= w_run_upd;
    end
  end

  assign bus.frame_max       = r_frame_max;
  assign bus.frame_max_valid = r_frame_max_valid;
`endif

endmodule

// File: tb/tb_dimming_mode_mux.sv
// tb_dimming_mode_mux: directed plus randomized stimulus for dimming_mode_mux with a scoreboard.
// Latency: expected results are stamped with the cycle they must appear in (issue + 2).
// Backpressure: the command model tracks the pending slot and expects drops while it is full.
module tb_dimming_mode_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dimming_mode_mux_if #(.DW(8), .CH(3), .VCNT_W(6)) bus ();

  dimming_mode_mux #(.DW(8), .CH(3), .VCNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [23:0] mean;
    logic [5:0]  vcnt;
    int          stamp;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  logic [7:0]  m_mode, m_sh_mode;
  logic [23:0] m_para, m_sh_para;
  bit          m_pend;
  bit          m_err_exp;
  logic [23:0] last_mean;
  logic [5:0]  last_vcnt;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] ref_calc(input logic [7:0] mode, input logic [23:0] para,
                                           input logic [7:0] w, input logic [23:0] col);
    logic [23:0] r;
    int          pc, cc, wv, p0, v;
    r  = '0;
    wv = int'(w);
    p0 = int'(para[7:0]);
    for (int c = 0; c < 3; c++) begin
      pc = int'(para[c*8 +: 8]);
      cc = int'(col[c*8 +: 8]);
      case (mode)
        8'hA0:   v = (wv > p0) ? wv - p0 : 0;
        8'hA1:   v = (wv * pc) / 256;
        8'hA2:   v = (cc * pc) / 256;
        default: v = (cc > pc) ? cc - pc : 0;
      endcase
      r[c*8 +: 8] = 8'(v);
    end
    return r;
  endfunction

  function automatic bit is_known(input logic [7:0] code);
    return (code == 8'hA0) || (code == 8'hA1) || (code == 8'hA2) || (code == 8'hA3);
  endfunction

  task automatic model_reset();
    m_mode    = 8'hA0;
    m_para    = '0;
    m_sh_mode = 8'hA0;
    m_sh_para = '0;
    m_pend    = 0;
    m_err_exp = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs and record what the DUT must do with them.
  task automatic prep(input bit cv, input logic [7:0] code, input logic [23:0] para, input bit fs,
                      input bit wv, input logic [7:0] wm, input logic [5:0] wvc,
                      input bit colv, input logic [23:0] cm, input logic [5:0] cvc);
    exp_t e;
    bit   white_mode;
    bus.cmd_valid   = cv;
    bus.cmd_code    = code;
    bus.para_list   = para;
    bus.frame_start = fs;
    bus.white_valid = wv;
    bus.white_mean  = wm;
    bus.white_v_cnt = wvc;
    bus.color_valid = colv;
    bus.color_mean  = cm;
    bus.color_v_cnt = cvc;
    white_mode = (m_mode == 8'hA0) || (m_mode == 8'hA1);
    if (white_mode ? wv : colv) begin
      e.mean  = ref_calc(m_mode, m_para, wm, cm);
      e.vcnt  = white_mode ? wvc : cvc;
      e.stamp = cyc + 2;
      exp_q.push_back(e);
    end
    m_err_exp = 0;
    if (m_pend) begin
      if (fs) begin
        m_mode = m_sh_mode;
        m_para = m_sh_para;
        m_pend = 0;
      end
    end else if (cv) begin
      if (is_known(code)) begin
        m_sh_mode = code;
        m_sh_para = para;
        m_pend    = 1;
      end else begin
        m_err_exp = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_pend));
    chk("active_mode", 32'(bus.active_mode), 32'(m_mode));
    chk("cmd_err", 32'(bus.cmd_err), 32'(m_err_exp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      prep(0, 8'h00, 24'h0, 0, 0, 8'h00, 6'd0, 0, 24'h0, 6'd0);
      step();
    end
  endtask

  task automatic cmd(input logic [7:0] code, input logic [23:0] para);
    prep(1, code, para, 0, 0, 8'h00, 6'd0, 0, 24'h0, 6'd0);
    step();
  endtask

  task automatic fstart();
    prep(0, 8'h00, 24'h0, 1, 0, 8'h00, 6'd0, 0, 24'h0, 6'd0);
    step();
  endtask

  task automatic white(input logic [7:0] w, input logic [5:0] vc);
    prep(0, 8'h00, 24'h0, 0, 1, w, vc, 0, 24'h0, 6'd0);
    step();
  endtask

  task automatic color(input logic [23:0] c, input logic [5:0] vc);
    prep(0, 8'h00, 24'h0, 0, 0, 8'h00, 6'd0, 1, c, vc);
    step();
  endtask

  // Monitor: pops the scoreboard on every out_valid; checks hold behaviour otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last_mean = '0;
      last_vcnt = '0;
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_mean", 32'(bus.out_mean), 32'(e.mean));
        chk("out_v_cnt", 32'(bus.out_v_cnt), 32'(e.vcnt));
        chk("latency_cycle", 32'(cyc), 32'(e.stamp));
        last_mean = e.mean;
        last_vcnt = e.vcnt;
      end
    end else begin
      chk("hold_out_mean", 32'(bus.out_mean), 32'(last_mean));
      chk("hold_out_v_cnt", 32'(bus.out_v_cnt), 32'(last_vcnt));
    end
  end

  initial begin
    logic [7:0]  rcode;
    logic [23:0] rpara;
    model_reset();
    last_mean = '0;
    last_vcnt = '0;
    bus.cmd_valid   = 0;
    bus.cmd_code    = '0;
    bus.para_list   = '0;
    bus.frame_start = 0;
    bus.white_valid = 0;
    bus.white_mean  = '0;
    bus.white_v_cnt = '0;
    bus.color_valid = 0;
    bus.color_mean  = '0;
    bus.color_v_cnt = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_mean", 32'(bus.out_mean), 32'd0);
    chk("rst_out_v_cnt", 32'(bus.out_v_cnt), 32'd0);
    chk("rst_active_mode", 32'(bus.active_mode), 32'hA0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    @(posedge clk);
    #1 rst = 0;

    // default mode A0 with zero threshold passes the grey value through
    white(8'h80, 6'd1);
    idle(3);

    // A0 threshold 0x30
    cmd(8'hA0, 24'h000030);
    fstart();
    white(8'h20, 6'd2);
    white(8'h50, 6'd3);
    idle(2);

    // A1 programmed; sample before frame_start still uses A0
    cmd(8'hA1, 24'hFF0080);
    white(8'hFF, 6'd4);
    fstart();
    white(8'hFF, 6'd5);
    idle(2);

    // A3, then a second command while pending is dropped
    cmd(8'hA3, 24'h1020FF);
    cmd(8'hA1, 24'h123456);
    fstart();
    color(24'h304010, 6'd6);
    color(24'h301040, 6'd7);
    idle(2);

    // unknown code, then A2 applied mid-stream with no bubble
    cmd(8'h55, 24'hABCDEF);
    idle(1);
    cmd(8'hA2, 24'h80C040);
    for (int i = 0; i < 6; i++) begin
      prep(0, 8'h00, 24'h0, (i == 2), 1, 8'($urandom), 6'(i), 1, 24'($urandom), 6'(i + 32));
      step();
    end
    idle(3);

    // reset with two samples in flight and a command pending
    cmd(8'hA1, 24'h808080);
    white(8'h40, 6'd10);                    // now in stage 1
    bus.white_valid = 1;                    // at the input, not yet captured
    bus.white_mean  = 8'h77;
    #2 rst = 1;
    model_reset();
    bus.white_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 0;
    idle(4);
    fstart();                               // lost command must not reappear
    idle(2);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 4))
        0:       rcode = 8'hA0;
        1:       rcode = 8'hA1;
        2:       rcode = 8'hA2;
        3:       rcode = 8'hA3;
        default: rcode = 8'($urandom);
      endcase
      rpara = 24'($urandom);
      prep(($urandom_range(0, 9) == 0), rcode, rpara, ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 2) != 0), 8'($urandom), 6'($urandom),
           ($urandom_range(0, 2) != 0), 24'($urandom), 6'($urandom));
      step();
    end
    idle(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
